e203_exu_csrctrl_mch: RTL and testbench

Parametrised successor CSR-instruction controller for the EXU ALU. It keeps the zero-latency path for core-local CSRs. It adds a multi-channel, multi-cycle external CSR port: split read/write transactions, read-modify-write sequencing for CSRRS/CSRRC, error responses and timeout. It sits between ALU dispatch, the core CSR file, and up to 4 external CSR agents (NICE-class accelerators).

---
 rtl/e203_exu_csrctrl_mch.sv | 279 +++++++++++++++++++++++++++
 tb/tb_e203_exu_csrctrl_mch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_csrctrl_mch.sv
// CSR-instruction controller: zero-latency path to the core CSR file plus a
// multi-channel, multi-cycle external CSR port with read-modify-write, errors and timeout.
module e203_exu_csrctrl_mch #(
  parameter int XLEN    = 32,
  parameter int EXT_CH  = 2,
  parameter int TMO_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   csr_i_valid,
  output logic                   csr_i_ready,
  input  logic [1:0]             csr_i_op,
  input  logic                   csr_i_rs1imm,
  input  logic                   csr_i_rs1is0,
  input  logic [4:0]             csr_i_zimm,
  input  logic [XLEN-1:0]        csr_i_rs1,
  input  logic [11:0]            csr_i_idx,
  input  logic                   csr_i_rdwen,

  output logic                   csr_ena,
  output logic                   csr_rd_en,
  output logic                   csr_wr_en,
  output logic [11:0]            csr_idx,
  input  logic                   csr_access_ilgl,
  input  logic [XLEN-1:0]        read_csr_dat,
  output logic [XLEN-1:0]        wbck_csr_dat,

  input  logic [EXT_CH-1:0]      ext_off,
  output logic [EXT_CH-1:0]      ext_req_valid,
  input  logic [EXT_CH-1:0]      ext_req_ready,
  output logic                   ext_req_wr,
  output logic [11:0]            ext_req_addr,
  output logic [XLEN-1:0]        ext_req_wdata,
  input  logic [EXT_CH-1:0]      ext_rsp_valid,
  input  logic [EXT_CH-1:0]      ext_rsp_err,
  input  logic [EXT_CH*XLEN-1:0] ext_rsp_rdata,
  output logic                   ext_rsp_ready,

  output logic                   csr_o_valid,
  input  logic                   csr_o_ready,
  output logic [XLEN-1:0]        csr_o_wbck_wdat,
  output logic                   csr_o_wbck_err,

  output logic                   csr_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RREQ,
    S_RRSP,
    S_WREQ,
    S_WRSP,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam int            CW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = (TMO_CYC > 0) ? CW'(TMO_CYC - 1) : '0;

  function automatic logic [XLEN-1:0] f_modify(input logic [1:0]      op,
                                               input logic [XLEN-1:0] op1,
                                               input logic [XLEN-1:0] old);
    case (op)
      OP_RW:   f_modify = op1;
      OP_RS:   f_modify = op1 | old;
      OP_RC:   f_modify = ~op1 & old;
      default: f_modify = old;
    endcase
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_op1;
  logic [11:0]       r_idx;
  logic [EXT_CH-1:0] r_ch_sel;
  logic              r_rdwen;
  logic              r_rs1is0;
  logic [XLEN-1:0]   r_old;
  logic              r_err;

  logic              w_latch;
  logic              w_old_cap;
  logic              w_err_nxt;

  // ---------------------------------------------------------------- decode
  logic [XLEN-1:0]   w_op1;
  logic              w_region;
  logic [EXT_CH-1:0] w_in_sel;
  logic              w_in_bad;
  logic              w_in_off;
  logic              w_is_ext;
  logic              w_in_rw;
  logic              w_in_rsrc;
  logic              w_in_need_rd;

  assign w_op1     = csr_i_rs1imm ? {{(XLEN-5){1'b0}}, csr_i_zimm} : csr_i_rs1;
  assign w_region  = (csr_i_idx[11:8] == 4'hE);

  always_comb begin
    for (int c = 0; c < EXT_CH; c++) begin
      w_in_sel[c] = (csr_i_idx[7:6] == 2'(c));
    end
  end

  // A channel number beyond EXT_CH leaves the one-hot select empty.
  assign w_in_bad     = w_region & ~(|w_in_sel);
  assign w_in_off     = w_region & (|(ext_off & w_in_sel));
  assign w_is_ext     = w_region & ~w_in_bad & ~w_in_off;
  assign w_in_rw      = (csr_i_op == OP_RW);
  assign w_in_rsrc    = (csr_i_op == OP_RS) | (csr_i_op == OP_RC);
  assign w_in_need_rd = w_in_rsrc | (w_in_rw & csr_i_rdwen);

  assign csr_idx      = csr_i_idx;
  assign wbck_csr_dat = f_modify(csr_i_op, w_op1, read_csr_dat);

  // ------------------------------------------------------ latched channel
  logic              w_sel_req_rdy;
  logic              w_sel_rsp_vld;
  logic              w_sel_rsp_err;
  logic [XLEN-1:0]   w_sel_rdata;
  logic              w_need_rd;
  logic              w_need_wr;
  logic [XLEN-1:0]   w_old_eff;
  logic              w_tmo;

  assign w_sel_req_rdy = |(ext_req_ready & r_ch_sel);
  assign w_sel_rsp_vld = |(ext_rsp_valid & r_ch_sel);
  assign w_sel_rsp_err = |(ext_rsp_err   & r_ch_sel);

  always_comb begin
    w_sel_rdata = '0;
    for (int c = 0; c < EXT_CH; c++) begin
      if (r_ch_sel[c]) w_sel_rdata = ext_rsp_rdata[c*XLEN +: XLEN];
    end
  end

  assign w_need_rd = (r_op == OP_RS) | (r_op == OP_RC) | ((r_op == OP_RW) & r_rdwen);
  assign w_need_wr = (r_op == OP_RW) | ~r_rs1is0;
  assign w_old_eff = w_need_rd ? r_old : '0;
  assign w_tmo     = (TMO_CYC != 0) && (r_cnt == TMO_LAST);

  assign ext_req_addr = r_idx;
  assign csr_busy     = (r_state != S_IDLE);

  // ----------------------------------------------- next state and outputs
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_latch         = 1'b0;
    w_old_cap       = 1'b0;
    w_err_nxt       = r_err;
    csr_i_ready     = 1'b0;
    csr_o_valid     = 1'b0;
    csr_o_wbck_wdat = '0;
    csr_o_wbck_err  = 1'b0;
    csr_rd_en       = 1'b0;
    csr_wr_en       = 1'b0;
    csr_ena         = 1'b0;
    ext_req_valid   = '0;
    ext_req_wr      = 1'b0;
    ext_req_wdata   = '0;
    ext_rsp_ready   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_is_ext) begin
          if (csr_i_valid) begin
            w_latch     = 1'b1;
            w_err_nxt   = 1'b0;
            w_state_nxt = w_in_need_rd ? S_RREQ : S_WREQ;
          end
        end else if (w_in_bad) begin
          csr_o_valid    = csr_i_valid;
          csr_o_wbck_err = 1'b1;
          csr_i_ready    = csr_o_ready;
        end else begin
          csr_o_valid     = csr_i_valid;
          csr_i_ready     = csr_o_ready;
          csr_o_wbck_wdat = read_csr_dat;
          csr_o_wbck_err  = csr_access_ilgl;
          csr_rd_en       = csr_i_valid & w_in_need_rd;
          csr_wr_en       = csr_i_valid & (w_in_rw | (w_in_rsrc & ~csr_i_rs1is0));
          csr_ena         = csr_i_valid & csr_o_ready;
        end
      end
      S_RREQ: begin
        ext_req_valid = r_ch_sel;
        if (w_sel_req_rdy) w_state_nxt = S_RRSP;
      end
      S_RRSP: begin
        ext_rsp_ready = 1'b1;
        if (w_sel_rsp_vld) begin
          w_old_cap = 1'b1;
          if (w_sel_rsp_err) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = w_need_wr ? S_WREQ : S_DONE;
          end
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_WREQ: begin
        ext_req_valid = r_ch_sel;
        ext_req_wr    = 1'b1;
        ext_req_wdata = f_modify(r_op, r_op1, w_old_eff);
        if (w_sel_req_rdy) w_state_nxt = S_WRSP;
      end
      S_WRSP: begin
        ext_rsp_ready = 1'b1;
        if (w_sel_rsp_vld) begin
          w_err_nxt   = w_sel_rsp_err;
          w_state_nxt = S_DONE;
        end else if (w_tmo) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        csr_o_valid     = 1'b1;
        csr_o_wbck_wdat = r_old;
        csr_o_wbck_err  = r_err;
        csr_i_ready     = csr_o_ready;
        if (csr_o_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------ registers
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: these are plain flops, not a memory array, so all of them take the
  // async reset and an aborted transaction leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_op1    <= '0;
      r_idx    <= '0;
      r_ch_sel <= '0;
      r_rdwen  <= 1'b0;
      r_rs1is0 <= 1'b0;
      r_old    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      // Wait counter restarts on every state change, so each response phase gets a full budget.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == S_RRSP) || (r_state == S_WRSP)) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_latch) begin
        r_op     <= csr_i_op;
        r_op1    <= w_op1;
        r_idx    <= csr_i_idx;
        r_ch_sel <= w_in_sel;
        r_rdwen  <= csr_i_rdwen;
        r_rs1is0 <= csr_i_rs1is0;
        r_old    <= '0;
      end else if (w_old_cap) begin
        r_old <= w_sel_rdata;
      end
    end
  end

endmodule

// File: tb/tb_e203_exu_csrctrl_mch.sv
// Scoreboard bench for e203_exu_csrctrl_mch: stimulus queues expected writebacks and
// external requests; independent monitors pop and compare as the DUT presents them.
module tb_e203_exu_csrctrl_mch;
  localparam int XLEN   = 32;
  localparam int EXT_CH = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   csr_i_valid;
  logic                   csr_i_ready;
  logic [1:0]             csr_i_op;
  logic                   csr_i_rs1imm;
  logic                   csr_i_rs1is0;
  logic [4:0]             csr_i_zimm;
  logic [XLEN-1:0]        csr_i_rs1;
  logic [11:0]            csr_i_idx;
  logic                   csr_i_rdwen;
  logic                   csr_ena;
  logic                   csr_rd_en;
  logic                   csr_wr_en;
  logic [11:0]            csr_idx;
  logic                   csr_access_ilgl;
  logic [XLEN-1:0]        read_csr_dat;
  logic [XLEN-1:0]        wbck_csr_dat;
  logic [EXT_CH-1:0]      ext_off;
  logic [EXT_CH-1:0]      ext_req_valid;
  logic [EXT_CH-1:0]      ext_req_ready;
  logic                   ext_req_wr;
  logic [11:0]            ext_req_addr;
  logic [XLEN-1:0]        ext_req_wdata;
  logic [EXT_CH-1:0]      ext_rsp_valid;
  logic [EXT_CH-1:0]      ext_rsp_err;
  logic [EXT_CH*XLEN-1:0] ext_rsp_rdata;
  logic                   ext_rsp_ready;
  logic                   csr_o_valid;
  logic                   csr_o_ready;
  logic [XLEN-1:0]        csr_o_wbck_wdat;
  logic                   csr_o_wbck_err;
  logic                   csr_busy;

  // Agent model: per-channel controls, ch1 data distinct from ch0.
  logic                   tb_req_rdy;
  logic [EXT_CH-1:0]      tb_rsp_vld;
  logic [EXT_CH-1:0]      tb_rsp_err;
  logic [XLEN-1:0]        tb_rdata0;
  logic [XLEN-1:0]        tb_rdata1;

  assign ext_req_ready = {EXT_CH{tb_req_rdy}};
  assign ext_rsp_valid = tb_rsp_vld;
  assign ext_rsp_err   = tb_rsp_err;
  assign ext_rsp_rdata = {tb_rdata1, tb_rdata0};

  e203_exu_csrctrl_mch #(.XLEN(XLEN), .EXT_CH(EXT_CH), .TMO_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_i_valid(csr_i_valid), .csr_i_ready(csr_i_ready), .csr_i_op(csr_i_op),
    .csr_i_rs1imm(csr_i_rs1imm), .csr_i_rs1is0(csr_i_rs1is0), .csr_i_zimm(csr_i_zimm),
    .csr_i_rs1(csr_i_rs1), .csr_i_idx(csr_i_idx), .csr_i_rdwen(csr_i_rdwen),
    .csr_ena(csr_ena), .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
    .csr_access_ilgl(csr_access_ilgl), .read_csr_dat(read_csr_dat), .wbck_csr_dat(wbck_csr_dat),
    .ext_off(ext_off), .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
    .ext_req_wr(ext_req_wr), .ext_req_addr(ext_req_addr), .ext_req_wdata(ext_req_wdata),
    .ext_rsp_valid(ext_rsp_valid), .ext_rsp_err(ext_rsp_err), .ext_rsp_rdata(ext_rsp_rdata),
    .ext_rsp_ready(ext_rsp_ready),
    .csr_o_valid(csr_o_valid), .csr_o_ready(csr_o_ready),
    .csr_o_wbck_wdat(csr_o_wbck_wdat), .csr_o_wbck_err(csr_o_wbck_err),
    .csr_busy(csr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] wdat;
    logic        err;
    int          lat;
    int          start;
  } rsp_t;

  typedef struct {
    logic [1:0]  vld;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
  } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];

  // Writeback monitor
  always @(negedge clk) begin
    if (rst_n && csr_o_valid && csr_o_ready) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got wdat=0x%0h err=%0b with nothing expected", csr_o_wbck_wdat, csr_o_wbck_err);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_wdat", csr_o_wbck_wdat, e.wdat);
        check("rsp_err", 32'(csr_o_wbck_err), 32'(e.err));
        check("rsp_lat", 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  // External request monitor
  always @(negedge clk) begin
    if (rst_n && (|(ext_req_valid & ext_req_ready))) begin
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexpected: got vld=%b wr=%0b addr=0x%0h with nothing expected", ext_req_valid, ext_req_wr, ext_req_addr);
      end else begin
        req_t e;
        e = req_q.pop_front();
        check("req_vld", 32'(ext_req_valid), 32'(e.vld));
        check("req_wr", 32'(ext_req_wr), 32'(e.wr));
        check("req_addr", 32'(ext_req_addr), 32'(e.addr));
        if (e.wr) check("req_wdata", ext_req_wdata, e.wdata);
      end
    end
  end

  task automatic push_req(input logic [1:0] vld, input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
    req_t r;
    r.vld = vld; r.wr = wr; r.addr = addr; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  // Snapshot of local strobes in the first cycle of each instruction.
  logic        s_ena, s_rd, s_wr;
  logic [31:0] s_wbck;
  logic [1:0]  s_reqv;

  task automatic txn(input logic [1:0] op, input logic imm, input logic is0, input logic [4:0] zimm,
                     input logic [31:0] rs1, input logic [11:0] idx, input logic rdwen,
                     input logic [31:0] exp_wdat, input logic exp_err, input int exp_lat);
    rsp_t r;
    int   n;
    @(posedge clk); #1;
    csr_i_op = op; csr_i_rs1imm = imm; csr_i_rs1is0 = is0; csr_i_zimm = zimm;
    csr_i_rs1 = rs1; csr_i_idx = idx; csr_i_rdwen = rdwen;
    csr_i_valid = 1'b1; csr_o_ready = 1'b1;
    r.wdat = exp_wdat; r.err = exp_err; r.lat = exp_lat; r.start = cyc;
    rsp_q.push_back(r);
    @(negedge clk);
    s_ena = csr_ena; s_rd = csr_rd_en; s_wr = csr_wr_en; s_wbck = wbck_csr_dat; s_reqv = ext_req_valid;
    n = 0;
    while (!csr_i_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!csr_i_ready) begin
      total++;
      bad++;
      $display("FAIL txn_timeout: idx=0x%0h never retired within 40 cycles", idx);
    end
    @(posedge clk); #1;
    csr_i_valid = 1'b0;
    check("rsp_drained", 32'(rsp_q.size()), 32'd0);
    check("req_drained", 32'(req_q.size()), 32'd0);
    rsp_q.delete();
    req_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    csr_i_valid = 1'b0; csr_i_op = 2'b00; csr_i_rs1imm = 1'b0; csr_i_rs1is0 = 1'b0;
    csr_i_zimm = '0; csr_i_rs1 = '0; csr_i_idx = '0; csr_i_rdwen = 1'b0;
    csr_access_ilgl = 1'b0; read_csr_dat = '0; ext_off = '0; csr_o_ready = 1'b0;
    tb_req_rdy = 1'b1; tb_rsp_vld = 2'b11; tb_rsp_err = 2'b00;
    tb_rdata0 = '0; tb_rdata1 = 32'hDEAD_BEEF;

    // Reset state
    #12;
    check("rst_busy", 32'(csr_busy), 32'd0);
    check("rst_req_valid", 32'(ext_req_valid), 32'd0);
    check("rst_o_valid", 32'(csr_o_valid), 32'd0);
    check("rst_rsp_ready", 32'(ext_rsp_ready), 32'd0);
    #11 rst_n = 1'b1;

    // Local RS: 0x8 | 0x1
    read_csr_dat = 32'h1;
    txn(2'b10, 1'b0, 1'b0, 5'd0, 32'h8, 12'h300, 1'b1, 32'h1, 1'b0, 0);
    check("loc_rs_wbck", s_wbck, 32'h9);
    check("loc_rs_ena", 32'(s_ena), 32'd1);
    check("loc_rs_wr", 32'(s_wr), 32'd1);
    check("loc_rs_rd", 32'(s_rd), 32'd1);

    // Local RW without rd, illegal access flagged
    read_csr_dat = 32'h10; csr_access_ilgl = 1'b1;
    txn(2'b01, 1'b0, 1'b0, 5'd0, 32'h77, 12'h340, 1'b0, 32'h10, 1'b1, 0);
    check("loc_rw_rd", 32'(s_rd), 32'd0);
    check("loc_rw_wr", 32'(s_wr), 32'd1);
    check("loc_rw_wbck", s_wbck, 32'h77);
    csr_access_ilgl = 1'b0;

    // Ext RW ch1, write only
    push_req(2'b10, 1'b1, 12'hE40, 32'hABCD);
    txn(2'b01, 1'b0, 1'b0, 5'd0, 32'hABCD, 12'hE40, 1'b0, 32'h0, 1'b0, 3);
    check("ext_rw_no_local_ena", 32'(s_ena), 32'd0);

    // Ext RC ch0 via zimm: read 0xF, write ~3 & 0xF
    tb_rdata0 = 32'hF;
    push_req(2'b01, 1'b0, 12'hE00, 32'h0);
    push_req(2'b01, 1'b1, 12'hE00, 32'hC);
    txn(2'b11, 1'b1, 1'b0, 5'd3, 32'hFFFF_FFFF, 12'hE00, 1'b1, 32'hF, 1'b0, 5);

    // Ext RS with rs1is0: read only
    tb_rdata0 = 32'h55;
    push_req(2'b01, 1'b0, 12'hE00, 32'h0);
    txn(2'b10, 1'b0, 1'b1, 5'd0, 32'h0, 12'hE00, 1'b1, 32'h55, 1'b0, 3);

    // Read response error: write skipped
    tb_rsp_err = 2'b01;
    push_req(2'b01, 1'b0, 12'hE05, 32'h0);
    txn(2'b10, 1'b0, 1'b0, 5'd0, 32'h1, 12'hE05, 1'b1, 32'h55, 1'b1, 3);
    tb_rsp_err = 2'b00;

    // Ext RS ch1: 0xF0 | 0x0F
    tb_rdata1 = 32'h0F;
    push_req(2'b10, 1'b0, 12'hE7F, 32'h0);
    push_req(2'b10, 1'b1, 12'hE7F, 32'hFF);
    txn(2'b10, 1'b0, 1'b0, 5'd0, 32'hF0, 12'hE7F, 1'b1, 32'h0F, 1'b0, 5);

    // Write response error
    tb_rsp_err = 2'b01;
    push_req(2'b01, 1'b1, 12'hE01, 32'h1);
    txn(2'b01, 1'b0, 1'b0, 5'd0, 32'h1, 12'hE01, 1'b0, 32'h0, 1'b1, 3);
    tb_rsp_err = 2'b00;

    // Timeout: 8 wait cycles in RRSP, then DONE with err
    tb_rsp_vld = 2'b00;
    push_req(2'b01, 1'b0, 12'hE00, 32'h0);
    txn(2'b10, 1'b0, 1'b1, 5'd0, 32'h0, 12'hE00, 1'b1, 32'h0, 1'b1, 10);
    tb_rsp_vld = 2'b11;
    @(negedge clk);
    check("late_rsp_ready", 32'(ext_rsp_ready), 32'd0);
    check("late_busy", 32'(csr_busy), 32'd0);

    // Channel beyond EXT_CH: immediate error, no strobes
    read_csr_dat = 32'h1234;
    txn(2'b01, 1'b0, 1'b0, 5'd0, 32'h5, 12'hEC0, 1'b1, 32'h0, 1'b1, 0);
    check("bad_ena", 32'(s_ena), 32'd0);
    check("bad_rd", 32'(s_rd), 32'd0);
    check("bad_wr", 32'(s_wr), 32'd0);
    check("bad_reqv", 32'(s_reqv), 32'd0);

    // Disabled channel routes to the local CSR file
    ext_off = 2'b01; read_csr_dat = 32'h5;
    txn(2'b10, 1'b0, 1'b0, 5'd0, 32'h2, 12'hE00, 1'b1, 32'h5, 1'b0, 0);
    check("off_wbck", s_wbck, 32'h7);
    check("off_ena", 32'(s_ena), 32'd1);
    check("off_reqv", 32'(s_reqv), 32'd0);
    ext_off = 2'b00;

    // Async reset while stalled in WREQ
    tb_req_rdy = 1'b0;
    @(posedge clk); #1;
    csr_i_op = 2'b01; csr_i_rs1imm = 1'b0; csr_i_rs1is0 = 1'b0; csr_i_rs1 = 32'h99;
    csr_i_idx = 12'hE40; csr_i_rdwen = 1'b0; csr_i_valid = 1'b1; csr_o_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("wreq_reqv", 32'(ext_req_valid), 32'h2);
    check("wreq_busy", 32'(csr_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_reqv", 32'(ext_req_valid), 32'd0);
    check("rst_mid_busy", 32'(csr_busy), 32'd0);
    check("rst_mid_wr", 32'(ext_req_wr), 32'd0);
    csr_i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tb_req_rdy = 1'b1;

    // Recovery: RW ch1 with rd, read 0x77 then write 0x1234
    tb_rdata1 = 32'h77;
    push_req(2'b10, 1'b0, 12'hE40, 32'h0);
    push_req(2'b10, 1'b1, 12'hE40, 32'h1234);
    txn(2'b01, 1'b0, 1'b0, 5'd0, 32'h1234, 12'hE40, 1'b1, 32'h77, 1'b0, 5);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
